// File: rtl/cache_pkg.sv
// Shared types for the set-associative write-back cache.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_pkg;

  typedef enum logic [1:0] {IDLE, WB, REFILL} state_t;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int OFS_W     = 2;
  // Widest tag any legal SET_BITS can produce; narrower tags are zero-extended.
  localparam int MAX_TAG_W = ADDR_W - OFS_W;

  // Tag width for a given index width.
  function automatic int tag_w(input int set_bits);
    return ADDR_W - OFS_W - set_bits;
  endfunction

  typedef logic [MAX_TAG_W-1:0] tag_t;

  typedef struct packed {
    logic                valid;
    logic                dirty;
    tag_t                tag;
    logic [DATA_W-1:0]   data;
  } line_t;

endpackage

// File: rtl/cache_sa_wb_if.sv
// CPU-side and memory-side signal bundle of the data cache.
// Latency: n/a (wiring only).
// Backpressure: cpu side via cpu_ready, memory side via mem_ack.
interface cache_sa_wb_if;
  // CPU load/store port
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  // Memory port
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  // The environment (CPU stage plus data memory) is the master, the cache the slave.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_rdata, cpu_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output cpu_rdata, cpu_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );
endinterface

// File: rtl/cache_lru.sv
// True-LRU age update for one set: accessed way -> age 0, younger ways age by one.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module cache_lru #(
  parameter int WAYS = 4,
  parameter int AW   = $clog2(WAYS)
) (
  input  logic [WAYS-1:0][AW-1:0] age_in,
  input  logic [AW-1:0]           acc_way,
  output logic [WAYS-1:0][AW-1:0] age_out,
  output logic [AW-1:0]           lru_way
);

  // Ages are a permutation, so exactly one way holds WAYS-1 (the LRU way).
  always_comb begin
    age_out = age_in;
    lru_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w == int'(acc_way))
        age_out[w] = '0;
      else if (age_in[w] < age_in[acc_way])
        age_out[w] = age_in[w] + AW'(1);
      if (age_in[w] == AW'(WAYS-1))
        lru_way = AW'(w);
    end
  end

endmodule

// File: rtl/cache_sa_wb.sv
// N-way set-associative write-back/write-allocate data cache, one word per line, true LRU.
// Latency: hit completes in the request cycle; miss = optional writeback + refill + re-lookup cycle.
// Backpressure: cpu_ready low while a miss is serviced; memory paced by mem_ack.
module cache_sa_wb
  import cache_pkg::*;
#(
  parameter int WAYS     = 4,
  parameter int SET_BITS = 6,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  cache_sa_wb_if.slave     bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int SETS    = 1 << SET_BITS;
  localparam int AW      = $clog2(WAYS);
  localparam int TAG_W   = tag_w(SET_BITS);
  localparam int TAG_LSB = ADDR_W - TAG_W;

  state_t state, state_nxt;

  line_t                  lines [SETS][WAYS];
  logic [WAYS-1:0][AW-1:0] ages [SETS];

  logic [SET_BITS-1:0] idx_c, lat_idx, cur_idx;
  tag_t                tag_c, lat_tag, wb_tag;
  logic [AW-1:0]       hit_way, victim, lat_way, acc_way, lru_way;
  logic [WAYS-1:0][AW-1:0] age_upd;
  logic                hit, inv_found, hit_acc, miss, wb_ack, fill_ack;
  logic                mem_req_q, refill_done;

  assign idx_c = bus.cpu_addr[SET_BITS+1:2];
  assign tag_c = tag_t'(bus.cpu_addr >> TAG_LSB);

  // Outside IDLE the only set touched is the latched miss set.
  assign cur_idx = (state == IDLE) ? idx_c : lat_idx;
  assign acc_way = (state == IDLE) ? hit_way : lat_way;

  assign hit_acc  = (state == IDLE) && bus.cpu_req && hit;
  assign miss     = (state == IDLE) && bus.cpu_req && !hit;
  assign wb_ack   = (state == WB) && mem_req_q && bus.mem_ack;
  assign fill_ack = (state == REFILL) && mem_req_q && bus.mem_ack;

  assign bus.mem_req = mem_req_q;

  cache_lru #(.WAYS(WAYS), .AW(AW)) u_lru (
    .age_in  (ages[cur_idx]),
    .acc_way (acc_way),
    .age_out (age_upd),
    .lru_way (lru_way)
  );

  // Tag compare across all ways of the addressed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (lines[idx_c][w].valid && (lines[idx_c][w].tag == tag_c)) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
    end
  end

  // Victim choice: lowest-index invalid way, otherwise the LRU way.
  always_comb begin
    victim    = lru_way;
    inv_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!inv_found && !lines[idx_c][w].valid) begin
        victim    = AW'(w);
        inv_found = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (miss)
          state_nxt = (lines[idx_c][victim].valid && lines[idx_c][victim].dirty) ? WB : REFILL;
      end
      WB:      if (wb_ack)   state_nxt = REFILL;
      REFILL:  if (fill_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // CPU response and memory address/data, all decoded from state and latched miss info.
  always_comb begin
    wb_tag        = lines[lat_idx][lat_way].tag;
    bus.cpu_ready = hit_acc;
    bus.cpu_rdata = hit_acc ? lines[idx_c][hit_way].data : '0;
    bus.mem_we    = (state == WB);
    bus.mem_addr  = ((state == WB) ? (32'(wb_tag) << TAG_LSB) : (32'(lat_tag) << TAG_LSB))
                  | (32'(lat_idx) << OFS_W);
    bus.mem_wdata = lines[lat_idx][lat_way].data;
  end

  // Registered memory request; it drops for one cycle between writeback and refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_q <= 1'b0;
    end else begin
      case (state)
        IDLE:    mem_req_q <= miss;
        WB:      mem_req_q <= !wb_ack;
        REFILL:  mem_req_q <= !fill_ack;
        default: mem_req_q <= 1'b0;
      endcase
    end
  end

  // Miss context capture and the refill marker that keeps the re-lookup out of hit_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_way     <= '0;
      lat_idx     <= '0;
      lat_tag     <= '0;
      refill_done <= 1'b0;
    end else begin
      refill_done <= fill_ack;
      if (miss) begin
        lat_way <= victim;
        lat_idx <= idx_c;
        lat_tag <= tag_c;
      end
    end
  end

  // Line storage and LRU ages: hit update/store merge, writeback clean, refill install.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          lines[s][w] <= '0;
          ages[s][w]  <= AW'(w);
        end
      end
    end else begin
      if (hit_acc) begin
        ages[idx_c] <= age_upd;
        if (bus.cpu_we) begin
          for (int b = 0; b < 4; b++)
            if (bus.cpu_be[b])
              lines[idx_c][hit_way].data[8*b +: 8] <= bus.cpu_wdata[8*b +: 8];
          lines[idx_c][hit_way].dirty <= 1'b1;
        end
      end
      if (wb_ack)
        lines[lat_idx][lat_way].dirty <= 1'b0;
      if (fill_ack) begin
        lines[lat_idx][lat_way] <= '{valid: 1'b1, dirty: 1'b0, tag: lat_tag, data: bus.mem_rdata};
        ages[lat_idx]           <= age_upd;
      end
    end
  end

  // Saturating hit/miss statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_acc && !refill_done && (hit_cnt != '1))
        hit_cnt <= hit_cnt + CNT_W'(1);
      if (miss && (miss_cnt != '1))
        miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cache_sa_wb.sv
// Randomized bench for cache_sa_wb against a recency-stamp cache model and a memory model.
// Latency: n/a.
// Backpressure: memory acks after a programmable delay per transaction kind.
module tb_cache_sa_wb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] hit_cnt, miss_cnt;

  cache_sa_wb_if bus();

  cache_sa_wb #(.WAYS(4), .SET_BITS(6), .CNT_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: 64 sets x 4 ways, recency by timestamp (bigger = more recent).
  logic        m_valid [64][4];
  logic        m_dirty [64][4];
  logic [23:0] m_tag   [64][4];
  logic [31:0] m_data  [64][4];
  int          m_stamp [64][4];
  int          tick;
  int          m_hits, m_miss;

  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] wb_q[$], wbd_q[$], rf_q[$];
  int          d_wb = 0, d_rf = 0;
  int          rdy_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return (a * 32'h9E3779B1) ^ 32'hC0FFEE11;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_tag[s][w]   = '0;
        m_data[s][w]  = '0;
        m_stamp[s][w] = -w;
      end
    tick = 0; m_hits = 0; m_miss = 0;
  endfunction

  function automatic void predict(input logic [31:0] addr, output bit hit, output int way);
    int idx;
    idx = int'(addr[7:2]);
    hit = 1'b0; way = -1;
    for (int w = 0; w < 4; w++)
      if (m_valid[idx][w] && m_tag[idx][w] == addr[31:8]) begin hit = 1'b1; way = w; end
    if (!hit) begin
      for (int w = 0; w < 4; w++)
        if (way < 0 && !m_valid[idx][w]) way = w;
      if (way < 0) begin
        way = 0;
        for (int w = 1; w < 4; w++)
          if (m_stamp[idx][w] < m_stamp[idx][way]) way = w;
      end
    end
  endfunction

  function automatic void commit(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [3:0] be, input bit hit, input int way, input bit merge);
    int idx;
    idx = int'(addr[7:2]);
    if (hit) m_hits++;
    else begin
      m_miss++;
      m_valid[idx][way] = 1'b1;
      m_dirty[idx][way] = 1'b0;
      m_tag[idx][way]   = addr[31:8];
      m_data[idx][way]  = mem_rd({addr[31:2], 2'b00});
    end
    tick++;
    m_stamp[idx][way] = tick;
    if (we && merge) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) m_data[idx][way][8*b +: 8] = wd[8*b +: 8];
      m_dirty[idx][way] = 1'b1;
    end
  endfunction

  // Memory responder: acks after d_wb/d_rf cycles of mem_req and logs each accepted transaction.
  initial begin
    int  hi;
    bit  gap_chk;
    hi = 0; gap_chk = 0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = $urandom;
      if (bus.cpu_ready) rdy_seen++;
      if (gap_chk) begin
        chk("wb_refill_gap", 32'(bus.mem_req), 32'd0);
        gap_chk = 0;
      end
      if (bus.mem_req && rst_n) begin
        if (hi == (bus.mem_we ? d_wb : d_rf)) begin
          bus.mem_ack = 1'b1;
          hi = 0;
          if (bus.mem_we) begin
            mem_m[bus.mem_addr] = bus.mem_wdata;
            wb_q.push_back(bus.mem_addr);
            wbd_q.push_back(bus.mem_wdata);
            gap_chk = 1;
          end else begin
            bus.mem_rdata = mem_rd(bus.mem_addr);
            rf_q.push_back(bus.mem_addr);
          end
        end else hi++;
      end else hi = 0;
    end
  end

  // One complete CPU access; starts and ends 1 time unit after a rising edge.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    bit hit, got, exp_wb;
    int way, idx, lat;
    logic [31:0] wb_a, wb_d, exp_rd;
    idx = int'(addr[7:2]);
    predict(addr, hit, way);
    exp_wb = !hit && m_valid[idx][way] && m_dirty[idx][way];
    wb_a   = {m_tag[idx][way], addr[7:2], 2'b00};
    wb_d   = m_data[idx][way];
    exp_rd = hit ? m_data[idx][way] : mem_rd({addr[31:2], 2'b00});
    wb_q.delete(); wbd_q.delete(); rf_q.delete();
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd; bus.cpu_be = be;
    lat = 0; got = 0;
    while (!got && lat < 100) begin
      @(negedge clk);
      if (bus.cpu_ready) begin
        got = 1;
        if (!we) chk("rdata", bus.cpu_rdata, exp_rd);
      end else lat++;
    end
    chk("ready_seen", 32'(got), 32'd1);
    if (hit) chk("hit_latency", 32'(lat), 32'd0);
    else if (!exp_wb) chk("miss_latency", 32'(lat), 32'(2 + d_rf));
    chk("wb_count", 32'(wb_q.size()), 32'(exp_wb));
    if (exp_wb && wb_q.size() > 0) begin
      chk("wb_addr", wb_q[0], wb_a);
      chk("wb_data", wbd_q[0], wb_d);
    end
    chk("refill_count", 32'(rf_q.size()), 32'(!hit));
    if (!hit && rf_q.size() > 0) chk("refill_addr", rf_q[0], {addr[31:2], 2'b00});
    @(posedge clk); #1;
    bus.cpu_req = 1'b0; bus.cpu_addr = $urandom; bus.cpu_we = 1'(($urandom));
    commit(we, addr, wd, be, hit, way, 1'b1);
    chk("hit_cnt", hit_cnt, 32'(m_hits));
    chk("miss_cnt", miss_cnt, 32'(m_miss));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bit hit;
    int way, n, rdy0;
    logic [31:0] a;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_be = '0;
    model_reset();
    do_reset();

    // Cold load miss, then a zero-latency hit.
    mem_m[32'h100] = 32'hDEADBEEF;
    d_rf = 2;
    access(1'b0, 32'h100, 32'h0, 4'h0);
    chk("s1_miss_cnt", miss_cnt, 32'd1);
    access(1'b0, 32'h100, 32'h0, 4'h0);
    chk("s1_hit_cnt", hit_cnt, 32'd1);

    // Partial store hit, then load the merged word.
    access(1'b1, 32'h100, 32'h12345678, 4'b0011);
    access(1'b0, 32'h100, 32'h0, 4'h0);
    chk("s2_merged", m_data[0][0], 32'hDEAD5678);

    // Fill set 0, the fifth tag evicts the dirty first line, the sixth a clean one.
    d_wb = 1; d_rf = 0;
    for (int i = 2; i <= 4; i++) access(1'b0, 32'(i) << 8, 32'h0, 4'h0);
    access(1'b0, 32'h500, 32'h0, 4'h0);
    chk("s3_evict_addr", (wb_q.size() > 0) ? wb_q[0] : 32'h0, 32'h100);
    chk("s3_evict_data", (wbd_q.size() > 0) ? wbd_q[0] : 32'h0, 32'hDEAD5678);
    access(1'b0, 32'h600, 32'h0, 4'h0);
    access(1'b0, 32'h100, 32'h0, 4'h0);

    // True LRU: A,B,C,D stored, A reused, E evicts B.
    for (int i = 0; i < 4; i++) access(1'b1, (32'(i) << 8) | 32'h4, $urandom, 4'hF);
    access(1'b0, 32'h004, 32'h0, 4'h0);
    access(1'b0, 32'h404, 32'h0, 4'h0);
    chk("s4_lru_victim", (wb_q.size() > 0) ? wb_q[0] : 32'h0, 32'h104);
    access(1'b0, 32'h004, 32'h0, 4'h0);

    // cpu_req dropped during a writeback: miss still finishes silently.
    for (int i = 0; i < 4; i++) access(1'b1, (32'(i) << 8) | 32'h8, $urandom, 4'hF);
    predict(32'h408, hit, way);
    wb_q.delete(); wbd_q.delete(); rf_q.delete();
    rdy0 = rdy_seen; d_wb = 3; d_rf = 2;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h408;
    n = 0;
    while (!(bus.mem_req && bus.mem_we) && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.cpu_req = 1'b0; bus.cpu_addr = $urandom;
    n = 0;
    while (rf_q.size() == 0 && n < 40) begin @(negedge clk); n++; end
    repeat (3) @(posedge clk);
    #1;
    chk("s6_wb_count", 32'(wb_q.size()), 32'd1);
    chk("s6_wb_addr", (wb_q.size() > 0) ? wb_q[0] : 32'h0, 32'h008);
    chk("s6_refill_count", 32'(rf_q.size()), 32'd1);
    chk("s6_no_ready", 32'(rdy_seen), 32'(rdy0));
    commit(1'b0, 32'h408, 32'h0, 4'h0, hit, way, 1'b0);
    chk("s6_miss_cnt", miss_cnt, 32'(m_miss));
    access(1'b0, 32'h408, 32'h0, 4'h0);

    // Reset while a refill is outstanding.
    d_rf = 6;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h014;
    n = 0;
    while (!bus.mem_req && n < 20) begin @(negedge clk); n++; end
    chk("s5_req_up", 32'(bus.mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("s5_async_drop", 32'(bus.mem_req), 32'd0);
    bus.cpu_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    d_rf = 1;
    access(1'b0, 32'h014, 32'h0, 4'h0);
    chk("s5_miss_after_rst", miss_cnt, 32'd1);

    // Random traffic over a few sets and tags.
    for (int i = 0; i < 250; i++) begin
      d_wb = $urandom_range(0, 3);
      d_rf = $urandom_range(0, 3);
      a = {21'h0, 3'($urandom_range(0, 5)), 6'($urandom_range(8, 11)), 2'($urandom)};
      access(1'($urandom), a, $urandom, 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
